// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, issues one-word I-cache reads and queues {pc, inst}
// pairs for rename/dispatch. A redirect flushes the queue and drops any in-flight response.
module fetch_unit #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              imem_addr,
  output logic [3:0]               imem_rmask,
  input  logic [31:0]              imem_rdata,
  input  logic                     imem_resp,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  entry_t             mem_q [DEPTH];

  logic issue;
  logic enq;
  logic deq;

  // Issuing only below FULL guarantees the single outstanding response always has a slot.
  assign issue = (state_q == IDLE) && !rst && !redirect_valid && (count_q < FULL);
  assign enq   = (state_q == WAIT) && imem_resp && !redirect_valid;
  assign deq   = out_valid && out_ready && !redirect_valid;

  // NOTE: every signal driven here gets its default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'd3;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      unique case (state_q)
        // A response arriving with the redirect retires the stale request immediately.
        WAIT, DROP: state_d = imem_resp ? IDLE : DROP;
        default:    state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: if (issue) state_d = WAIT;
        WAIT: if (imem_resp) begin
          state_d    = IDLE;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
        DROP: if (imem_resp) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (enq) tail_d = tail_q + PTR_W'(1);
      if (deq) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; count and pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= '{pc: fetch_pc_q, inst: imem_rdata};
  end

  assign imem_addr  = fetch_pc_q;
  assign imem_rmask = issue ? 4'hF : 4'h0;
  assign out_valid  = (count_q != '0);
  assign out_count  = count_q;
  assign out_pc     = mem_q[head_q].pc;
  assign out_inst   = mem_q[head_q].inst;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle-level I-cache model, scoreboard of expected
// {pc, inst} pairs, a vector table for the first fetches and directed redirect/reset cases.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 16;
  localparam logic [31:0] RESET_PC = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [$clog2(DEPTH):0] out_count;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_count      (out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic        ready;
    logic [3:0]  rmask;
    logic [31:0] addr;
    int          count;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        sb[$];
  logic [31:0] exp_pc = RESET_PC;
  logic        stale = 1'b0;
  logic        orphan = 1'b0;
  logic        cache_busy = 1'b0;
  logic [31:0] cache_addr = '0;
  int          cache_cnt = 0;
  int          cache_lat = 2;
  int          req_cnt = 0;
  int          enq_cnt = 0;
  logic [31:0] last_req_addr = '0;
  logic [3:0]  s_rmask;
  logic [31:0] s_addr;
  int          s_count;
  logic        s_valid;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_0f0f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at a falling edge. Drives the cache model,
  // checks outputs against the scoreboard, then advances the reference model.
  task automatic step();
    logic resp_now;
    logic exp_issue;
    exp_t e;
    resp_now   = cache_busy && (cache_cnt == 0);
    imem_resp  = resp_now || orphan;
    imem_rdata = resp_now ? inst_of(cache_addr) : 32'hdead_beef;
    exp_issue  = 1'b0;
    #1;
    s_rmask = imem_rmask;
    s_addr  = imem_addr;
    s_count = int'(out_count);
    s_valid = out_valid;
    if (!rst) begin
      exp_issue = !cache_busy && !redirect_valid && (sb.size() < DEPTH);
      check("rmask", 32'(imem_rmask), exp_issue ? 32'hF : 32'h0);
      if (exp_issue) check("req_addr", imem_addr, exp_pc);
      check("out_count", 32'(out_count), 32'(sb.size()));
      check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      if (out_valid && sb.size() != 0) begin
        check("head_pc", out_pc, sb[0].pc);
        check("head_inst", out_inst, sb[0].inst);
      end
    end
    if (imem_rmask == 4'hF) begin
      req_cnt++;
      last_req_addr = imem_addr;
    end
    orphan = 1'b0;
    if (rst) begin
      sb.delete();
      exp_pc = RESET_PC;
      stale  = 1'b0;
      if (cache_busy && !resp_now) orphan = 1'b1;
      cache_busy = 1'b0;
    end else if (redirect_valid) begin
      sb.delete();
      exp_pc = redirect_pc & ~32'd3;
      if (resp_now) begin
        cache_busy = 1'b0;
        stale      = 1'b0;
      end else if (cache_busy) begin
        stale = 1'b1;
      end
    end else begin
      if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
      if (resp_now) begin
        if (!stale) begin
          e.pc = cache_addr;
          e.inst = inst_of(cache_addr);
          sb.push_back(e);
          exp_pc = exp_pc + 32'd4;
          enq_cnt++;
        end
        stale = 1'b0;
        cache_busy = 1'b0;
      end
    end
    if (exp_issue) begin
      cache_busy = 1'b1;
      cache_addr = exp_pc;
      cache_cnt  = cache_lat - 1;
    end else if (cache_busy) begin
      cache_cnt--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req(input string name, input int bound);
    int base;
    base = req_cnt;
    for (int i = 0; i < bound && req_cnt == base; i++) step();
    check(name, 32'(req_cnt != base), 32'h1);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  vec_t tbl[10];

  initial begin
    int base;
    tbl[0] = '{1'b0, 4'hF, 32'h1eceb000, 0};
    tbl[1] = '{1'b0, 4'h0, 32'h0,        0};
    tbl[2] = '{1'b0, 4'h0, 32'h0,        0};
    tbl[3] = '{1'b0, 4'hF, 32'h1eceb004, 1};
    tbl[4] = '{1'b0, 4'h0, 32'h0,        1};
    tbl[5] = '{1'b0, 4'h0, 32'h0,        1};
    tbl[6] = '{1'b0, 4'hF, 32'h1eceb008, 2};
    tbl[7] = '{1'b0, 4'h0, 32'h0,        2};
    tbl[8] = '{1'b0, 4'h0, 32'h0,        2};
    tbl[9] = '{1'b0, 4'hF, 32'h1eceb00c, 3};

    rst = 1'b1; imem_resp = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset state, then the first fetches with a two-cycle cache.
    step();
    #1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_count", 32'(out_count), 32'h0);
    check("rst_rmask", 32'(imem_rmask), 32'h0);
    @(negedge clk);
    step();
    rst = 1'b0;
    cache_lat = 2;
    for (int i = 0; i < 10; i++) begin
      out_ready = tbl[i].ready;
      step();
      check($sformatf("vec%0d_rmask", i), 32'(s_rmask), 32'(tbl[i].rmask));
      if (tbl[i].rmask == 4'hF) check($sformatf("vec%0d_addr", i), s_addr, tbl[i].addr);
      check($sformatf("vec%0d_count", i), 32'(s_count), 32'(tbl[i].count));
    end

    // Fill to DEPTH with no consumer; a single dequeue must release exactly one request.
    cache_lat = 1;
    for (int i = 0; i < 300 && !(sb.size() == DEPTH && !cache_busy); i++) step();
    check("fill_timeout", 32'(sb.size() == DEPTH && !cache_busy), 32'h1);
    base = req_cnt;
    for (int i = 0; i < 10; i++) step();
    check("full_no_req", 32'(req_cnt - base), 32'h0);
    check("full_count", 32'(out_count), 32'(DEPTH));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("one_req_after_deq", 32'(req_cnt - base), 32'h1);
    check("refill_count", 32'(out_count), 32'(DEPTH));

    // Redirect while WAIT; the response three cycles later is dropped.
    redirect(32'h1eceb040);
    cache_lat = 5;
    wait_req("t3_issue_timeout", 20);
    cache_cnt = 3;
    redirect(32'h1eceb100);
    for (int i = 0; i < 3; i++) step();
    check("t3_count_after_drop", 32'(out_count), 32'h0);
    wait_req("t3_req_timeout", 10);
    check("t3_redirect_addr", last_req_addr, 32'h1eceb100);

    // Redirect in the same cycle as the response; unaligned target.
    cache_lat = 2;
    for (int i = 0; i < 10 && cache_busy; i++) step();
    wait_req("t4_issue_timeout", 10);
    step();
    check("t4_resp_due", 32'(cache_busy && cache_cnt == 0), 32'h1);
    redirect(32'h1eceb203);
    wait_req("t4_req_timeout", 10);
    check("t4_redirect_addr", last_req_addr, 32'h1eceb200);
    check("t4_no_enq", 32'(out_count), 32'h0);

    // Simultaneous enqueue and dequeue at DEPTH-1, then ordering across pointer wrap.
    cache_lat = 1;
    redirect(32'h1eceb300);
    for (int i = 0; i < 300 && !(sb.size() == DEPTH - 1 && cache_busy && cache_cnt == 0); i++) step();
    check("t5_fill_timeout", 32'(sb.size() == DEPTH - 1 && cache_busy && cache_cnt == 0), 32'h1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t5_count_same", 32'(out_count), 32'(DEPTH - 1));
    redirect(32'h1eceb400);
    base = enq_cnt;
    for (int i = 0; i < 2000 && (enq_cnt - base) < 40; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    check("t5_wrap_enq", 32'((enq_cnt - base) >= 40), 32'h1);
    out_ready = 1'b0;

    // Reset during WAIT with the response arriving the cycle after reset.
    cache_lat = 3;
    for (int i = 0; i < 10 && cache_busy; i++) step();
    if (sb.size() >= DEPTH) redirect(32'h1eceb500);
    wait_req("t6_issue_timeout", 10);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    base = req_cnt;
    step();
    check("t6_late_resp_valid", 32'(s_valid), 32'h0);
    check("t6_first_req", 32'(req_cnt - base), 32'h1);
    check("t6_req_addr", last_req_addr, RESET_PC);
    for (int i = 0; i < 6; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
